// File: rtl/alu16_pkg.sv
// Shared definitions for the 16-bit ALU issue/writeback controller.
// Op encoding maps op[0] to ALU sel0 and op[1] to ALU sel1.
package alu16_pkg;
   localparam int WIDTH     = 16;
   localparam int NREGS     = 8;
   localparam int REG_IDX_W = $clog2(NREGS);

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;
endpackage

// File: rtl/alu16_regfile.sv
// Register file with two combinational operand reads, a debug read and one write port.
// r0 is hard-wired to zero: writes to it are dropped and reads return 0.
module alu16_regfile #(
   parameter int WIDTH = alu16_pkg::WIDTH,
   parameter int NREGS = alu16_pkg::NREGS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_we,
   input  logic [$clog2(NREGS)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic [$clog2(NREGS)-1:0] i_raddr_a,
   output logic [WIDTH-1:0]         o_rdata_a,
   input  logic [$clog2(NREGS)-1:0] i_raddr_b,
   output logic [WIDTH-1:0]         o_rdata_b,
   input  logic [$clog2(NREGS)-1:0] i_dbg_raddr,
   output logic [WIDTH-1:0]         o_dbg_rdata
);
   import alu16_pkg::*;

   logic [WIDTH-1:0] r_mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      end else if (i_we && (i_waddr != '0)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a   = (i_raddr_a   == '0) ? '0 : r_mem[i_raddr_a];
   assign o_rdata_b   = (i_raddr_b   == '0) ? '0 : r_mem[i_raddr_b];
   assign o_dbg_rdata = (i_dbg_raddr == '0) ? '0 : r_mem[i_dbg_raddr];
endmodule

// File: rtl/alu16_issue_ctrl.sv
// Two-stage issue/writeback controller around an external combinational 16-bit ALU.
// ID reads operands (with EX->ID forwarding), EX drives the ALU, WB holds the result under backpressure.
module alu16_issue_ctrl #(
   parameter int WIDTH = alu16_pkg::WIDTH,
   parameter int NREGS = alu16_pkg::NREGS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     instr_valid,
   output logic                     instr_ready,
   input  logic [1:0]               instr_op,
   input  logic [$clog2(NREGS)-1:0] instr_rd,
   input  logic [$clog2(NREGS)-1:0] instr_rs1,
   input  logic [$clog2(NREGS)-1:0] instr_rs2,
   input  logic                     instr_imm_en,
   input  logic [WIDTH-1:0]         instr_imm,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   output logic                     alu_sel0,
   output logic                     alu_sel1,
   input  logic [WIDTH-1:0]         alu_out,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [$clog2(NREGS)-1:0] wb_rd,
   output logic [WIDTH-1:0]         wb_data,
   output logic                     wb_zero,
   input  logic [$clog2(NREGS)-1:0] dbg_raddr,
   output logic [WIDTH-1:0]         dbg_rdata
);
   import alu16_pkg::*;

   localparam int IDX_W = $clog2(NREGS);

   logic             r_ex_valid;
   logic [WIDTH-1:0] r_ex_a;
   logic [WIDTH-1:0] r_ex_b;
   alu_op_e          r_ex_op;
   logic [IDX_W-1:0] r_ex_rd;
   logic             r_wb_valid;
   logic [IDX_W-1:0] r_wb_rd;
   logic [WIDTH-1:0] r_wb_data;
   logic             r_wb_zero;

   logic             w_wb_adv;
   logic             w_ex_adv;
   logic             w_accept;
   logic             w_fwd_a;
   logic             w_fwd_b;
   logic [WIDTH-1:0] w_rf_a;
   logic [WIDTH-1:0] w_rf_b;
   logic [WIDTH-1:0] w_opa;
   logic [WIDTH-1:0] w_opb;

   assign w_wb_adv    = !r_wb_valid || wb_ready;
   assign w_ex_adv    = r_ex_valid && w_wb_adv;
   assign instr_ready = !r_ex_valid || w_wb_adv;
   assign w_accept    = instr_valid && instr_ready;

   alu16_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_we        (w_ex_adv),
      .i_waddr     (r_ex_rd),
      .i_wdata     (alu_out),
      .i_raddr_a   (instr_rs1),
      .o_rdata_a   (w_rf_a),
      .i_raddr_b   (instr_rs2),
      .o_rdata_b   (w_rf_b),
      .i_dbg_raddr (dbg_raddr),
      .o_dbg_rdata (dbg_rdata)
   );

   // The result leaving EX this edge is not yet in the register file, so bypass it.
   assign w_fwd_a = w_ex_adv && (r_ex_rd != '0) && (r_ex_rd == instr_rs1);
   assign w_fwd_b = w_ex_adv && (r_ex_rd != '0) && (r_ex_rd == instr_rs2) && !instr_imm_en;
   assign w_opa   = w_fwd_a ? alu_out : w_rf_a;
   assign w_opb   = instr_imm_en ? instr_imm : (w_fwd_b ? alu_out : w_rf_b);

   // ID -> EX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid <= 1'b0;
         r_ex_a     <= '0;
         r_ex_b     <= '0;
         r_ex_op    <= ALU_ADD;
         r_ex_rd    <= '0;
      end else if (w_accept) begin
         r_ex_valid <= 1'b1;
         r_ex_a     <= w_opa;
         r_ex_b     <= w_opb;
         r_ex_op    <= alu_op_e'(instr_op);
         r_ex_rd    <= instr_rd;
      end else if (w_ex_adv) begin
         r_ex_valid <= 1'b0;
      end
   end

   assign alu_a    = r_ex_valid ? r_ex_a : '0;
   assign alu_b    = r_ex_valid ? r_ex_b : '0;
   assign alu_sel0 = r_ex_valid & r_ex_op[0];
   assign alu_sel1 = r_ex_valid & r_ex_op[1];

   // EX -> WB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_wb_zero  <= 1'b0;
      end else if (w_ex_adv) begin
         r_wb_valid <= 1'b1;
         r_wb_rd    <= r_ex_rd;
         r_wb_data  <= alu_out;
         r_wb_zero  <= (alu_out == '0);
      end else if (r_wb_valid && wb_ready) begin
         r_wb_valid <= 1'b0;
      end
   end

   assign wb_valid = r_wb_valid;
   assign wb_rd    = r_wb_rd;
   assign wb_data  = r_wb_data;
   assign wb_zero  = r_wb_zero;
endmodule

// File: tb/tb_alu16_issue_ctrl.sv
// Bench for alu16_issue_ctrl: behavioural ALU, in-order architectural reference model and scoreboard.
module tb_alu16_issue_ctrl;
   import alu16_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [1:0]  instr_op = 2'b00;
   logic [2:0]  instr_rd = 3'd0;
   logic [2:0]  instr_rs1 = 3'd0;
   logic [2:0]  instr_rs2 = 3'd0;
   logic        instr_imm_en = 1'b0;
   logic [15:0] instr_imm = 16'd0;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_sel0;
   logic        alu_sel1;
   logic [15:0] alu_out;
   logic        wb_valid;
   logic        wb_ready = 1'b1;
   logic [2:0]  wb_rd;
   logic [15:0] wb_data;
   logic        wb_zero;
   logic [2:0]  dbg_raddr = 3'd0;
   logic [15:0] dbg_rdata;

   always #5 clk = ~clk;

   always_comb begin
      alu_out = 16'd0;
      case ({alu_sel1, alu_sel0})
         2'b00:   alu_out = alu_a + alu_b;
         2'b01:   alu_out = alu_a - alu_b;
         2'b10:   alu_out = alu_a & alu_b;
         default: alu_out = alu_a | alu_b;
      endcase
   end

   alu16_issue_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_op     (instr_op),
      .instr_rd     (instr_rd),
      .instr_rs1    (instr_rs1),
      .instr_rs2    (instr_rs2),
      .instr_imm_en (instr_imm_en),
      .instr_imm    (instr_imm),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_sel0     (alu_sel0),
      .alu_sel1     (alu_sel1),
      .alu_out      (alu_out),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .wb_zero      (wb_zero),
      .dbg_raddr    (dbg_raddr),
      .dbg_rdata    (dbg_rdata)
   );

   typedef struct {
      logic [2:0]  rd;
      logic [15:0] data;
      logic        zero;
   } wb_t;

   wb_t         exp_q[$];
   logic [15:0] m_regs [8];
   int          n_tests = 0;
   int          n_fail = 0;
   logic        rand_bp = 1'b0;
   logic        last_acc = 1'b0;
   logic        prev_stall = 1'b0;
   logic        prev_irdy = 1'b1;
   logic [19:0] prev_wb = '0;
   logic [33:0] prev_alu = '0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a | b;
      endcase
   endfunction

   task automatic clear_model();
      exp_q.delete();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
      prev_stall = 1'b0;
   endtask

   // One clock: observe at the falling edge, return just after the next rising edge.
   task automatic tick();
      wb_t         e;
      wb_t         got;
      logic [15:0] b;
      @(negedge clk);
      last_acc = 1'b0;
      if (instr_valid && instr_ready) begin
         b = instr_imm_en ? instr_imm : m_regs[instr_rs2];
         e.rd   = instr_rd;
         e.data = ref_op(instr_op, m_regs[instr_rs1], b);
         e.zero = (e.data == 16'd0);
         if (instr_rd != 3'd0) m_regs[instr_rd] = e.data;
         exp_q.push_back(e);
         last_acc = 1'b1;
      end
      if (prev_stall) begin
         check_eq("bp_wb_valid", 64'(wb_valid), 64'd1);
         check_eq("bp_wb_hold", 64'({wb_rd, wb_data, wb_zero}), 64'(prev_wb));
         if (!prev_irdy)
            check_eq("bp_alu_hold", 64'({alu_sel1, alu_sel0, alu_a, alu_b}), 64'(prev_alu));
      end
      if (wb_valid && wb_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("wb_extra_result", 64'(wb_data), 64'hDEAD_0000_0000);
         end else begin
            got = exp_q.pop_front();
            check_eq("wb_rd", 64'(wb_rd), 64'(got.rd));
            check_eq("wb_data", 64'(wb_data), 64'(got.data));
            check_eq("wb_zero", 64'(wb_zero), 64'(got.zero));
         end
      end
      prev_stall = wb_valid && !wb_ready;
      prev_irdy  = instr_ready;
      prev_wb    = {wb_rd, wb_data, wb_zero};
      prev_alu   = {alu_sel1, alu_sel0, alu_a, alu_b};
      @(posedge clk);
      #1;
      if (rand_bp) wb_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm);
      instr_op     = op;
      instr_rd     = rd;
      instr_rs1    = rs1;
      instr_rs2    = rs2;
      instr_imm_en = imm_en;
      instr_imm    = imm;
      instr_valid  = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (last_acc) break;
      end
      if (!last_acc) check_eq("issue_timeout", 64'd0, 64'd1);
      instr_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
      check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reg(input int idx, input logic [15:0] exp);
      dbg_raddr = 3'(idx);
      #1;
      check_eq($sformatf("dbg_r%0d", idx), 64'(dbg_rdata), 64'(exp));
   endtask

   task automatic realign();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] imm;
      clear_model();
      #8;
      check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
      check_eq("rst_instr_ready", 64'(instr_ready), 64'd1);
      check_eq("rst_alu_drive", 64'({alu_sel1, alu_sel0, alu_a, alu_b}), 64'd0);
      check_eq("rst_wb_regs", 64'({wb_rd, wb_data, wb_zero}), 64'd0);
      #4 rst_n = 1'b1;
      realign();

      // Basic sequence and debug read
      issue(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5);
      issue(ALU_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'd3);
      issue(ALU_SUB, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0);
      drain();
      check_reg(3, 16'd2);
      realign();

      // Back-to-back dependency through the bypass
      issue(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF);
      issue(ALU_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 16'd1);
      drain();
      check_reg(1, 16'h8000);
      realign();

      // Wraparound, zero flag, subtract from r0
      issue(ALU_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 16'hFFFF);
      issue(ALU_ADD, 3'd5, 3'd4, 3'd0, 1'b1, 16'd1);
      issue(ALU_SUB, 3'd6, 3'd0, 3'd4, 1'b0, 16'd0);
      drain();
      check_reg(5, 16'h0000);
      check_reg(6, 16'h0001);
      realign();

      // r0 destination is presented but not stored
      issue(ALU_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'd9);
      issue(ALU_OR, 3'd7, 3'd0, 3'd0, 1'b0, 16'd0);
      drain();
      check_reg(0, 16'd0);
      check_reg(7, 16'd0);
      realign();

      // Backpressure with both stages occupied
      wb_ready = 1'b0;
      issue(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0011);
      issue(ALU_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0022);
      for (int k = 0; k < 3; k++) begin
         check_eq("bp_instr_ready", 64'(instr_ready), 64'd0);
         tick();
      end
      wb_ready = 1'b1;
      drain();
      check_reg(2, 16'h0033);
      realign();

      // Randomized traffic with random backpressure
      rand_bp = 1'b1;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0:       imm = 16'h0000;
            1:       imm = 16'hFFFF;
            2:       imm = 16'h8000;
            default: imm = 16'($urandom);
         endcase
         issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), imm);
         if ($urandom_range(0, 7) == 0) tick();
      end
      rand_bp  = 1'b0;
      wb_ready = 1'b1;
      drain();
      for (int i = 0; i < 8; i++) check_reg(i, m_regs[i]);
      realign();

      // Asynchronous reset while stalled
      wb_ready = 1'b0;
      issue(ALU_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0055);
      issue(ALU_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0066);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_wb_valid", 64'(wb_valid), 64'd0);
      check_eq("arst_instr_ready", 64'(instr_ready), 64'd1);
      check_eq("arst_alu_drive", 64'({alu_sel1, alu_sel0, alu_a, alu_b}), 64'd0);
      for (int i = 0; i < 8; i++) check_reg(i, 16'd0);
      rst_n = 1'b1;
      clear_model();
      realign();
      wb_ready = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      issue(ALU_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 16'd4);
      drain();
      check_reg(2, 16'd4);
      check_reg(1, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
